// File: rtl/int_reg_file.sv
// int_reg_file: 2-read/1-write integer register file, registered reads, x0 reads as zero.
// Define INT_REG_FILE_BYPASS_EN for write-first forwarding on read/write collisions.
module int_reg_file #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] readAddr1,
  input  logic [ADDR_WIDTH-1:0] readAddr2,
  output logic [DATA_WIDTH-1:0] readValue1,
  output logic [DATA_WIDTH-1:0] readValue2,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [DATA_WIDTH-1:0] writeValue,
  input  logic                  writeEnable,
  output logic                  ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clear_index;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  write_en_c;
  logic [DATA_WIDTH-1:0] read_data1_c;
  logic [DATA_WIDTH-1:0] read_data2_c;

  assign write_en_c = (state == RUN) && writeEnable && (writeAddr != '0);

  // Next read data per port; x0 overrides everything, including forwarding.
  always_comb begin
    read_data1_c = mem[readAddr1];
    read_data2_c = mem[readAddr2];
`ifdef INT_REG_FILE_BYPASS_EN
    if (write_en_c && (writeAddr == readAddr1)) read_data1_c = writeValue;
    if (write_en_c && (writeAddr == readAddr2)) read_data2_c = writeValue;
`endif
    if (readAddr1 == '0) read_data1_c = '0;
    if (readAddr2 == '0) read_data2_c = '0;
  end

  // Control FSM: clear sweep after reset, then service the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clear_index <= '0;
      ready       <= 1'b0;
      readValue1  <= '0;
      readValue2  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          readValue1 <= '0;
          readValue2 <= '0;
          if (clear_index == LAST_INDEX) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            clear_index <= clear_index + ADDR_WIDTH'(1);
          end
        end
        RUN: begin
          readValue1 <= read_data1_c;
          readValue2 <= read_data2_c;
        end
      endcase
    end
  end

  // Storage array: no reset, every entry is defined by the sweep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clear_index] <= '0;
      end else if (write_en_c) begin
        mem[writeAddr] <= writeValue;
      end
    end
  end

endmodule

// File: tb/tb_int_reg_file.sv
// Self-checking bench for int_reg_file: directed scenarios plus randomized traffic
// compared every cycle against an array-based model of the register file.
module tb_int_reg_file;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2 ** AW;
`ifdef INT_REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] readAddr1 = '0;
  logic [AW-1:0] readAddr2 = '0;
  logic [DW-1:0] readValue1;
  logic [DW-1:0] readValue2;
  logic [AW-1:0] writeAddr = '0;
  logic [DW-1:0] writeValue = '0;
  logic          writeEnable = 1'b0;
  logic          ready;

  int n_checks = 0;
  int n_fail   = 0;

  int_reg_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .readAddr1  (readAddr1),
    .readAddr2  (readAddr2),
    .readValue1 (readValue1),
    .readValue2 (readValue2),
    .writeAddr  (writeAddr),
    .writeValue (writeValue),
    .writeEnable(writeEnable),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register contents plus remaining sweep length.
  logic [DW-1:0] regs [DEPTH];
  logic [DW-1:0] m_rv1 = '0;
  logic [DW-1:0] m_rv2 = '0;
  logic          m_ready = 1'b0;
  bit            model_valid = 1'b0;
  int            sweep_left = 0;

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (BYPASS && writeEnable && (writeAddr == a)) return writeValue;
    return regs[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_valid = 1'b1;
      m_ready     = 1'b0;
      m_rv1       = '0;
      m_rv2       = '0;
      sweep_left  = DEPTH;
    end else if (model_valid) begin
      if (sweep_left > 0) begin
        m_rv1 = '0;
        m_rv2 = '0;
        sweep_left--;
        if (sweep_left == 0) begin
          for (int i = 0; i < DEPTH; i++) regs[i] = '0;
          m_ready = 1'b1;
        end
      end else begin
        m_rv1 = model_read(readAddr1);
        m_rv2 = model_read(readAddr2);
        if (writeEnable && (writeAddr != '0)) regs[writeAddr] = writeValue;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("ready", DW'(ready), DW'(m_ready));
      check("readValue1", readValue1, m_rv1);
      check("readValue2", readValue2, m_rv2);
    end
  end

  // Apply one cycle of inputs; returns 2 time units after the consuming edge.
  task automatic cyc(input logic r, input logic we, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wv, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rst = r; writeEnable = we; writeAddr = wa; writeValue = wv;
    readAddr1 = a1; readAddr2 = a2;
    @(posedge clk);
    #2;
  endtask

  // Run cycles holding the given write until ready rises; n = edges taken.
  task automatic wait_ready(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wv,
                            output int n);
    n = 0;
    while (!ready && n < 100) begin
      cyc(1'b0, we, wa, wv, wa, wa);
      n++;
    end
    if (!ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: ready still %b after %0d cycles", ready, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [AW-1:0] wa, a1, a2;

    // Reset sweep with a write held on x3 that must be ignored.
    cyc(1'b1, 1'b0, '0, '0, '0, '0);
    check("reset_ready", DW'(ready), '0);
    check("reset_rv1", readValue1, '0);
    check("reset_rv2", readValue2, '0);
    wait_ready(1'b1, AW'(3), 32'hFFFF_FFFF, n);
    check("sweep_len", DW'(n), DW'(32));
    cyc(1'b0, 1'b0, '0, '0, AW'(3), '0);
    check("x3_after_sweep", readValue1, 32'h0);

    // Basic write then dual read.
    cyc(1'b0, 1'b1, AW'(5), 32'hDEAD_BEEF, '0, '0);
    cyc(1'b0, 1'b0, '0, '0, AW'(5), AW'(5));
    check("x5_port1", readValue1, 32'hDEAD_BEEF);
    check("x5_port2", readValue2, 32'hDEAD_BEEF);

    // x0 hardwire.
    cyc(1'b0, 1'b1, AW'(0), 32'h1234_5678, '0, '0);
    cyc(1'b0, 1'b0, '0, '0, AW'(0), AW'(0));
    check("x0_read", readValue1, 32'h0);

    // Collision on x7.
    cyc(1'b0, 1'b1, AW'(7), 32'h1111_1111, '0, '0);
    cyc(1'b0, 1'b1, AW'(7), 32'h2222_2222, '0, AW'(7));
    check("collision", readValue2, BYPASS ? 32'h2222_2222 : 32'h1111_1111);
    cyc(1'b0, 1'b0, '0, '0, '0, AW'(7));
    check("after_collision", readValue2, 32'h2222_2222);

    // Reset mid-sweep at clearIndex 10.
    cyc(1'b1, 1'b0, '0, '0, '0, '0);
    repeat (10) cyc(1'b0, 1'b0, '0, '0, '0, '0);
    check("midsweep_ready", DW'(ready), '0);
    cyc(1'b1, 1'b0, '0, '0, '0, '0);
    wait_ready(1'b0, '0, '0, n);
    check("midsweep_len", DW'(n), DW'(32));

    // Reset coincident with a write of x9.
    cyc(1'b0, 1'b1, AW'(5), 32'h5555_AAAA, '0, '0);
    cyc(1'b1, 1'b1, AW'(9), 32'hCAFE_F00D, AW'(5), AW'(5));
    check("rst_write_rv1", readValue1, '0);
    check("rst_write_rv2", readValue2, '0);
    check("rst_write_ready", DW'(ready), '0);
    wait_ready(1'b0, '0, '0, n);
    check("rst_write_len", DW'(n), DW'(32));
    cyc(1'b0, 1'b0, '0, '0, AW'(9), AW'(5));
    check("x9_cleared", readValue1, 32'h0);
    check("x5_cleared", readValue2, 32'h0);

    // Randomized traffic with occasional resets, biased toward low addresses.
    for (int i = 0; i < 3000; i++) begin
      wa = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH - 1));
      a1 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH - 1));
      a2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 7));
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0), wa, DW'($urandom()), a1, a2);
    end
    cyc(1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
